// File: rtl/tetris_pkg.sv
// tetris_pkg: types shared by the phase sequencer and the per-row blocks.
//  phase_t  : 3-bit phase code broadcast to every row
//  state_t  : sequencer state encoding
//  phase_of : phase code presented while the sequencer sits in a given state
package tetris_pkg;

   localparam int TETRIS_ROWS = 20;

   typedef enum logic [2:0] {
      PH_CHECK = 3'b000,
      PH_MOVE  = 3'b001,
      PH_WRITE = 3'b010,
      PH_SHIFT = 3'b011,
      PH_ADD   = 3'b100
   } phase_t;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADD       = 4'd1,
      ST_SPAWN_CHK = 4'd2,
      ST_FALL      = 4'd3,
      ST_MOVE      = 4'd4,
      ST_WRITE     = 4'd5,
      ST_SCAN      = 4'd6,
      ST_SHIFT     = 4'd7,
      ST_SETTLE    = 4'd8,
      ST_OVER      = 4'd9
   } state_t;

   function automatic phase_t phase_of(input state_t st);
      phase_t ph;
      case (st)
         ST_ADD:   ph = PH_ADD;
         ST_MOVE:  ph = PH_MOVE;
         ST_WRITE: ph = PH_WRITE;
         ST_SHIFT: ph = PH_SHIFT;
         default:  ph = PH_CHECK;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/tetris_phase_ctrl_drop_timer.sv
// tetris_phase_ctrl_drop_timer: gravity pacing counter.
//  clk_i   : clock             rst_ni : async active-low reset
//  en_i    : count enable      clr_i  : synchronous clear to 0
//  fast_i  : select FAST_TICKS period instead of DROP_TICKS
//  term_o  : high for the single cycle in which the counter sits on (or past) the
//            last count of the selected period; the counter then returns to 0.
// Using >= for the terminal test lets a period shortening mid-count (soft drop
// rising late) terminate on the very next cycle.
module tetris_phase_ctrl_drop_timer
   import tetris_pkg::*;
#(
   parameter int DROP_TICKS = 25_000_000,
   parameter int FAST_TICKS = 2_500_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   input  logic fast_i,
   output logic term_o
);

   localparam int MAXT = (DROP_TICKS > FAST_TICKS) ? DROP_TICKS : FAST_TICKS;
   localparam int CW   = (MAXT > 2) ? $clog2(MAXT) : 1;
   localparam logic [CW-1:0] DROP_LAST = CW'(DROP_TICKS - 1);
   localparam logic [CW-1:0] FAST_LAST = CW'(FAST_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] last_s;

   // Period select, terminal detect and next count.
   always_comb begin
      if (fast_i) begin
         last_s = FAST_LAST;
      end else begin
         last_s = DROP_LAST;
      end
      term_o = en_i && (cnt_q >= last_s);
      if (clr_i) begin
         cnt_d = {CW{1'b0}};
      end else if (!en_i) begin
         cnt_d = cnt_q;
      end else if (term_o) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1'b1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tetris_phase_ctrl.sv
// tetris_phase_ctrl: game sequencer driving the phase code to all row blocks.
//  clk, reset (async active-low), start (level, IDLE only)
//  stop_any, endgame_any : OR-reduced row flags
//  row_full [ROWS]       : per-row full flags from the board
//  phase [3]             : registered phase code
//  clear_sel [ROWS]      : one-hot row to delete, only during the shift phase
//  lines [16]            : saturating count of rows cleared this game
//  game_over, busy       : registered status
// Optional feature macro TETRIS_SOFT_DROP_EN adds input soft_drop, which selects
// the FAST_TICKS gravity period while high.
module tetris_phase_ctrl
   import tetris_pkg::*;
#(
   parameter int ROWS       = TETRIS_ROWS,
   parameter int DROP_TICKS = 25_000_000,
   parameter int FAST_TICKS = 2_500_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
`ifdef TETRIS_SOFT_DROP_EN
   input  logic            soft_drop,
`endif
   input  logic            stop_any,
   input  logic            endgame_any,
   input  logic [ROWS-1:0] row_full,
   output logic [2:0]      phase,
   output logic [ROWS-1:0] clear_sel,
   output logic [15:0]     lines,
   output logic            game_over,
   output logic            busy
);

   localparam int SW = $clog2(ROWS + 1);
   localparam logic [SW-1:0]   SCAN_END = SW'(ROWS);
   localparam logic [ROWS-1:0] ROW_ONE  = ROWS'(1'b1);

   state_t          state_q, state_d;
   phase_t          phase_q, phase_d;
   logic [SW-1:0]   scan_q, scan_d;
   logic [15:0]     lines_q, lines_d;
   logic [ROWS-1:0] clear_sel_q, clear_sel_d;
   logic            game_over_q, game_over_d;
   logic            busy_q, busy_d;

   logic            fall_s;
   logic            fast_s;
   logic            drop_term_s;
   logic [ROWS-1:0] scan_onehot_s;
   logic            row_hit_s;

   assign fall_s = (state_q == ST_FALL);

`ifdef TETRIS_SOFT_DROP_EN
   assign fast_s = soft_drop;
`else
   assign fast_s = 1'b0;
`endif

   // Timer is held at 0 outside FALL so each FALL entry starts a full period.
   tetris_phase_ctrl_drop_timer #(
      .DROP_TICKS (DROP_TICKS),
      .FAST_TICKS (FAST_TICKS)
   ) u_drop_timer (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (fall_s),
      .clr_i  (!fall_s),
      .fast_i (fast_s),
      .term_o (drop_term_s)
   );

   // Shift-based select avoids indexing past the top row when scan_q == ROWS.
   assign scan_onehot_s = ROW_ONE << scan_q;
   assign row_hit_s     = |(row_full & scan_onehot_s);

   // Next-state logic; outputs are derived from the next state so they register with it.
   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      lines_d = lines_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ADD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADD: begin
            state_d = ST_SPAWN_CHK;
         end
         ST_SPAWN_CHK: begin
            // Collision on spawn ends the game even if stop_any is also high.
            if (endgame_any) begin
               state_d = ST_OVER;
            end else begin
               state_d = ST_FALL;
            end
         end
         ST_FALL: begin
            if (drop_term_s && stop_any) begin
               state_d = ST_WRITE;
            end else if (drop_term_s) begin
               state_d = ST_MOVE;
            end else begin
               state_d = ST_FALL;
            end
         end
         ST_MOVE: begin
            state_d = ST_FALL;
         end
         ST_WRITE: begin
            state_d = ST_SCAN;
            scan_d  = {SW{1'b0}};
         end
         ST_SCAN: begin
            if (scan_q == SCAN_END) begin
               state_d = ST_ADD;
            end else if (row_hit_s) begin
               state_d = ST_SHIFT;
            end else begin
               scan_d = scan_q + SW'(1'b1);
            end
         end
         ST_SHIFT: begin
            state_d = ST_SETTLE;
            if (lines_q != 16'hFFFF) begin
               lines_d = lines_q + 16'd1;
            end else begin
               lines_d = lines_q;
            end
         end
         ST_SETTLE: begin
            // Same index again: the rows above have dropped into this slot.
            state_d = ST_SCAN;
         end
         ST_OVER: begin
            state_d = ST_OVER;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      phase_d     = phase_of(state_d);
      game_over_d = (state_d == ST_OVER);
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_OVER);
      if (state_d == ST_SHIFT) begin
         clear_sel_d = scan_onehot_s;
      end else begin
         clear_sel_d = {ROWS{1'b0}};
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= PH_CHECK;
         scan_q      <= {SW{1'b0}};
         lines_q     <= 16'd0;
         clear_sel_q <= {ROWS{1'b0}};
         game_over_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         scan_q      <= scan_d;
         lines_q     <= lines_d;
         clear_sel_q <= clear_sel_d;
         game_over_q <= game_over_d;
         busy_q      <= busy_d;
      end
   end

   assign phase     = phase_q;
   assign clear_sel = clear_sel_q;
   assign lines     = lines_q;
   assign game_over = game_over_q;
   assign busy      = busy_q;

endmodule
